// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO: buffers {address, instruction} pairs from fetch
// and presents the oldest pair to decode through a valid/ready handshake.
module fetch_queue #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    enq_valid,
   output logic                    enq_ready,
   input  logic [ADDR_WIDTH-1:0]   enq_addr,
   input  logic [DATA_WIDTH-1:0]   enq_instruction,
   output logic                    deq_valid,
   input  logic                    deq_ready,
   output logic [ADDR_WIDTH-1:0]   deq_addr,
   output logic [DATA_WIDTH-1:0]   deq_instruction,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ADDR_WIDTH-1:0] addr_mem  [DEPTH];
   logic [DATA_WIDTH-1:0] instr_mem [DEPTH];

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count_q;

   logic enq_fire;
   logic deq_fire;

   // DEPTH is a power of two, so the natural binary overflow is the wrap.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return p + 1'b1;
   endfunction

   function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] c,
                                                   input logic inc,
                                                   input logic dec);
      logic [CNT_W-1:0] r;
      case ({inc, dec})
         2'b10:   r = c + 1'b1;
         2'b01:   r = c - 1'b1;
         default: r = c;
      endcase
      return r;
   endfunction

   // Ready depends only on registered occupancy, so a full queue never reuses
   // the slot being dequeued in the same cycle.
   assign enq_ready = (count_q != FULL_CNT) && !rst && !flush;
   assign deq_valid = (count_q != '0);
   assign enq_fire  = enq_valid && enq_ready;
   assign deq_fire  = deq_valid && deq_ready && !rst && !flush;

   assign deq_addr        = deq_valid ? addr_mem[rd_ptr]  : '0;
   assign deq_instruction = deq_valid ? instr_mem[rd_ptr] : '0;
   assign count           = count_q;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (enq_fire) wr_ptr <= ptr_inc(wr_ptr);
         if (deq_fire) rd_ptr <= ptr_inc(rd_ptr);
         count_q <= count_next(count_q, enq_fire, deq_fire);
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (enq_fire) begin
         addr_mem[wr_ptr]  <= enq_addr;
         instr_mem[wr_ptr] <= enq_instruction;
      end
   end

   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count_q <= FULL_CNT);

   a_no_enq_when_full: assert property (@(posedge clk) disable iff (rst)
      (count_q == FULL_CNT) |-> !enq_fire);

   a_ptr_consistent: assert property (@(posedge clk) disable iff (rst)
      (wr_ptr - rd_ptr) == count_q[PTR_W-1:0]);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed test-plan steps followed by random traffic,
// every output compared each cycle against a queue-based reference model.
module tb_fetch_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        enq_valid;
   logic        enq_ready;
   logic [31:0] enq_addr;
   logic [31:0] enq_instruction;
   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_addr;
   logic [31:0] deq_instruction;
   logic [3:0]  count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } pair_t;

   pair_t mq[$];

   always #5 clk = ~clk;

   fetch_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_addr(enq_addr), .enq_instruction(enq_instruction),
      .deq_valid(deq_valid), .deq_ready(deq_ready),
      .deq_addr(deq_addr), .deq_instruction(deq_instruction),
      .count(count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs with the model, take the edge.
   task automatic cycle(input logic r, input logic f, input logic ev,
                        input logic [31:0] ea, input logic [31:0] ed, input logic dr);
      logic        exp_rdy;
      logic        exp_vld;
      logic [31:0] exp_a;
      logic [31:0] exp_d;
      pair_t       p;
      rst = r; flush = f; enq_valid = ev; enq_addr = ea; enq_instruction = ed; deq_ready = dr;
      #1;
      exp_rdy = !r && !f && (mq.size() < DEPTH);
      exp_vld = (mq.size() != 0);
      exp_a   = exp_vld ? mq[0].a : 32'h0;
      exp_d   = exp_vld ? mq[0].d : 32'h0;
      check("enq_ready", {31'b0, enq_ready}, {31'b0, exp_rdy});
      check("deq_valid", {31'b0, deq_valid}, {31'b0, exp_vld});
      check("deq_addr", deq_addr, exp_a);
      check("deq_instruction", deq_instruction, exp_d);
      check("count", {28'b0, count}, 32'(mq.size()));
      @(posedge clk);
      if (r || f) begin
         mq.delete();
      end else begin
         if (exp_vld && dr) void'(mq.pop_front());
         if (ev && exp_rdy) begin
            p.a = ea;
            p.d = ed;
            mq.push_back(p);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic dr);
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, dr);
   endtask

   task automatic push(input logic [31:0] a, input logic dr);
      cycle(1'b0, 1'b0, 1'b1, a, 32'h00000013 + a, dr);
   endtask

   initial begin
      logic [31:0] a;
      rst = 1'b1; flush = 1'b0; enq_valid = 1'b1; enq_addr = 32'h0;
      enq_instruction = 32'h0; deq_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);

      // Reset held three cycles while fetch offers a pair
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 32'h40, 32'h53, 1'b0);
      idle(1'b0);

      // Fill to full, then offer a ninth pair that must not be taken
      for (int i = 0; i < 8; i++) push(32'(i * 4), 1'b0);
      check("full_count", {28'b0, count}, 32'd8);
      for (int i = 0; i < 3; i++) push(32'h20, 1'b0);

      // Drain everything in order
      for (int i = 0; i < 9; i++) idle(1'b1);
      check("drained_addr", deq_addr, 32'h0);

      // Steady-state concurrent traffic at occupancy three, wrapping pointers
      for (int i = 0; i < 3; i++) push(32'h400 + 32'(i * 4), 1'b0);
      for (int i = 0; i < 20; i++) push(32'h500 + 32'(i * 4), 1'b1);
      check("steady_count", {28'b0, count}, 32'd3);
      for (int i = 0; i < 4; i++) idle(1'b1);

      // Back-pressure: head must hold while two more arrive
      cycle(1'b0, 1'b0, 1'b1, 32'h100, 32'h00A00093, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i < 2) push(32'h104 + 32'(i * 4), 1'b0);
         else       idle(1'b0);
         check("bp_head_addr", deq_addr, 32'h100);
         check("bp_head_instr", deq_instruction, 32'h00A00093);
      end
      check("bp_count", {28'b0, count}, 32'd3);

      // Flush at occupancy six with a colliding enqueue and dequeue
      for (int i = 0; i < 3; i++) push(32'h180 + 32'(i * 4), 1'b0);
      cycle(1'b0, 1'b1, 1'b1, 32'h200, 32'h213, 1'b1);
      check("post_flush_count", {28'b0, count}, 32'd0);
      push(32'h300, 1'b0);
      check("post_flush_head", deq_addr, 32'h300);
      idle(1'b1);

      // Flush while empty, then reset mid-traffic
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) push(32'h600 + 32'(i * 4), 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 32'h700, 32'h713, 1'b1);
      idle(1'b0);

      // Random traffic with occasional flush and reset
      for (int i = 0; i < 400; i++) begin
         a = $urandom;
         cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4),
               ($urandom_range(0, 99) < 65), a, $urandom,
               ($urandom_range(0, 99) < 50));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling FIFO between the instruction fetch stage and InstructionDecode.
- Buffers {instruction address, instruction word} pairs from fetch and presents the oldest pair to decode with a valid/ready handshake.
- Absorbs decode/rename back-pressure without stalling fetch until the queue is full.
- Discards all buffered instructions on a pipeline flush (branch mispredict, exception redirect).

Parameters:
- ADDR_WIDTH, 32, width of the instruction address.
- DATA_WIDTH, 32, width of the instruction word.
- DEPTH, 8, number of entries; power of two, minimum 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous queue clear; highest priority after rst.
- enq_valid  input  1  fetch presents a valid pair.
- enq_ready  output  1  queue accepts a pair this cycle.
- enq_addr  input  ADDR_WIDTH  instruction address from fetch.
- enq_instruction  input  DATA_WIDTH  instruction word from fetch.
- deq_valid  output  1  head entry valid for decode.
- deq_ready  input  1  decode consumes head this cycle.
- deq_addr  output  ADDR_WIDTH  head instruction address; feeds decode instruction_addr.
- deq_instruction  output  DATA_WIDTH  head instruction word; feeds decode instruction.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset state:
  - Applies on any edge with rst=1.
  - rd_ptr=0, wr_ptr=0, count=0.
  - Outputs during and after reset: deq_valid=0, deq_addr=0, deq_instruction=0.
  - enq_ready=0 while rst=1, and 1 on the first cycle after reset.
  - Storage array is not reset.
- Handshakes:
  - Enqueue fires when enq_valid && enq_ready.
  - Dequeue fires when deq_valid && deq_ready.
  - enq_ready = (count != DEPTH) && !rst && !flush. It is purely a function of registered count plus rst/flush and never depends on deq_ready, so there is no same-cycle slot reuse when full.
  - deq_valid = (count != 0).
  - deq_addr/deq_instruction are a combinational read of mem[rd_ptr] when deq_valid=1, and forced to 0 when deq_valid=0.
- Latency: an entry enqueued at edge N is visible on deq_* in cycle N+1. There is no enqueue-to-dequeue bypass.
- Ordering: strict FIFO. Address/instruction pairs are never split or reordered.
- Stability: while deq_valid=1 and deq_ready=0, deq_addr/deq_instruction hold stable until dequeued or flushed.
- Pointer update:
  - Enqueue writes mem[wr_ptr] and then increments wr_ptr.
  - Dequeue increments rd_ptr.
  - Both pointers wrap from DEPTH-1 to 0.
- Count update:
  - Enqueue only: count+1.
  - Dequeue only: count-1.
  - Both, or neither: unchanged.
  - count never exceeds DEPTH and never underflows; the handshake rules guarantee this, and an assertion checks it.
- Flush:
  - rd_ptr, wr_ptr and count go to 0 at the edge; deq_valid=0 the next cycle.
  - enq_ready=0 during the flush cycle, so a simultaneous enq_valid is dropped.
  - A dequeue handshake in the flush cycle is ignored by the queue; decode is also flushed.
- Full: enq_ready=0. Fetch must hold enq_* stable until accepted.
- Empty: deq_valid=0. deq_ready is ignored.
- Simultaneous rst and flush: rst governs; the result is identical.
- Reset mid-operation: all buffered entries are discarded, with the same state as power-up reset.
- Flush when empty: no effect beyond enq_ready=0 for that cycle.

Test Plan:
- Reset: hold rst=1 for 3 cycles with enq_valid=1 -> deq_valid=0, count=0, enq_ready=0 during reset; enq_ready=1 in the first post-reset cycle.
- Fill:
  - Stimulus: deq_ready=0; enqueue addr 0x000..0x01C step 4 with instruction=0x00000013+addr.
  - Response: count reaches 8; enq_ready=0 after the 8th edge; a 9th pair (addr 0x020) is not accepted.
- Drain:
  - Stimulus: from full, deq_ready=1.
  - Response: deq_addr sequence is 0x000,0x004,...,0x01C with matching instructions, one per cycle; deq_valid=0 and deq_addr=0 after the 8th.
- Concurrent enqueue/dequeue and wrap-around:
  - Stimulus: hold count=3, then enq and deq every cycle for 20 cycles.
  - Response: count stays 3; pointers wrap at least twice; output order equals input order.
- Back-pressure:
  - Stimulus: head addr 0x100, instruction 0x00A00093; deq_ready=0 for 5 cycles while enqueuing 2 more.
  - Response: deq_addr=0x100 and deq_instruction=0x00A00093 stable for all 5 cycles; count 1->3.
- Flush:
  - Stimulus: count=6; assert flush with enq_valid=1 (addr 0x200) and deq_ready=1.
  - Response: next cycle count=0, deq_valid=0, and 0x200 never appears.
  - Follow-up: next enqueue of addr 0x300 appears at the head one cycle later.
